pipeline_hazard_ctrl: RTL

Interlock and sequencing controller for the 20-bit five-stage pipeline. It observes the instruction in ID, branch resolution in EX and data-memory busy status, and drives the write enables and flush/bubble controls of PC, IF/ID and ID/EX. A 3-entry destination scoreboard tracks writers in EX, MEM and WB. The pipeline has no forwarding, so every RAW hazard is resolved by stalling.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 54 +++++
 rtl/pipeline_hazard_ctrl_if.sv | 30 +++
 rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv | 52 +++++
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose: shared decode constants, state encodings and helpers for the hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pkg;

  // Instruction field positions
  localparam int OP_HI = 19;
  localparam int OP_LO = 16;
  localparam int RA_LO = 12;
  localparam int RB_LO = 8;
  localparam int RC_LO = 4;

  // Opcodes; 10..15 fall through to NOP behaviour
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;
  localparam logic [3:0] OP_JMP  = 4'd9;

  localparam logic [19:0] NOP_INSTR = 20'h00000;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_RAW_STALL = 2'd1,
    ST_BR_FLUSH  = 2'd2,
    ST_MEM_HOLD  = 2'd3
  } ctrl_state_e;

  // ADD..LD write ra
  function automatic logic writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LD);
  endfunction

  // rb is read by every writer plus ST and BEQ
  function automatic logic reads_rb(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_BEQ);
  endfunction

  // rc is read only by the three-register ALU ops
  function automatic logic reads_rc(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  // ra is a source only for ST and BEQ
  function automatic logic reads_ra(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Purpose: bundle of ID/EX/MEM observations and pipeline control outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; master drives observations, slave drives controls.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [19:0]      id_instruction;
  logic             id_valid;
  logic             ex_branch_taken;
  logic             mem_busy;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_hold;
  logic [1:0]       ctrl_state;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_instruction, id_valid, ex_branch_taken, mem_busy,
    input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           pipe_hold, ctrl_state, stall_count
  );

  modport slave (
    input  id_instruction, id_valid, ex_branch_taken, mem_busy,
    output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           pipe_hold, ctrl_state, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_scoreboard.sv
// Purpose: DEPTH-entry shift register of in-flight destinations (entry 0 = EX) and RAW match.
// Latency: hazard is combinational on the current entries; entries update on the next edge.
// Backpressure: advance = 0 freezes all entries.
// Ports: clock/reset; advance, load_vld/load_dest (new entry 0); src_vld/src_addr (3 sources); hazard.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int DEPTH = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      advance,
  input  logic                      load_vld,
  input  logic [REG_W-1:0]          load_dest,
  input  logic [2:0]                src_vld,
  input  logic [2:0][REG_W-1:0]     src_addr,
  output logic                      hazard
);
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][REG_W-1:0] dest_q, dest_d;

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    if (reset) begin
      valid_d = '0;
      dest_d  = '0;
    end else if (advance) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        dest_d[i]  = dest_q[i-1];
      end
      valid_d[0] = load_vld;
      dest_d[0]  = load_dest;
    end
  end

  always_ff @(posedge clock) begin
    valid_q <= valid_d;
    dest_q  <= dest_d;
  end

  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (src_vld[s] && valid_q[e] && (src_addr[s] == dest_q[e])) begin
          hazard = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush/hold interlock for the no-forwarding five-stage pipeline.
// Latency: controls are combinational (Mealy); ctrl_state and stall_count lag by one edge.
// Backpressure: mem_busy freezes the whole pipe; RAW hazards stall PC and IF/ID with a bubble.
// Ports: clock, reset (sync, active-high); bus.slave carries ID/EX/MEM inputs and all controls.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = 4,
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  bus
);
  logic [19:0]           instr;
  logic [3:0]            op;
  logic [REG_W-1:0]      ra, rb, rc;
  logic [2:0]            src_vld;
  logic [2:0][REG_W-1:0] src_addr;
  logic                  hazard;
  logic                  advance;
  logic                  load_vld;
  logic                  unused_low_bits;

  ctrl_state_e      sel, state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign instr           = bus.id_instruction;
  assign op              = instr[OP_HI:OP_LO];
  assign ra              = instr[RA_LO +: REG_W];
  assign rb              = instr[RB_LO +: REG_W];
  assign rc              = instr[RC_LO +: REG_W];
  assign unused_low_bits = ^instr[3:0];

  // r0 is hard-wired zero, so it is never a source of a hazard
  always_comb begin
    src_vld[0]  = bus.id_valid && reads_rb(op) && (rb != '0);
    src_vld[1]  = bus.id_valid && reads_rc(op) && (rc != '0);
    src_vld[2]  = bus.id_valid && reads_ra(op) && (ra != '0);
    src_addr[0] = rb;
    src_addr[1] = rc;
    src_addr[2] = ra;
  end

  always_comb begin
    bus.pc_write_en    = 1'b0;
    bus.if_id_write_en = 1'b0;
    bus.if_id_flush    = 1'b0;
    bus.id_ex_bubble   = 1'b0;
    bus.pipe_hold      = 1'b0;
    sel                = ST_RUN;
    if (reset) begin
      bus.if_id_flush  = 1'b1;
      bus.id_ex_bubble = 1'b1;
    end else if (bus.mem_busy) begin
      sel           = ST_MEM_HOLD;
      bus.pipe_hold = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // IF/ID is loaded with a NOP while the PC takes the target
      sel                = ST_BR_FLUSH;
      bus.pc_write_en    = 1'b1;
      bus.if_id_write_en = 1'b1;
      bus.if_id_flush    = 1'b1;
      bus.id_ex_bubble   = 1'b1;
    end else if (hazard) begin
      sel              = ST_RAW_STALL;
      bus.id_ex_bubble = 1'b1;
    end else begin
      bus.pc_write_en    = 1'b1;
      bus.if_id_write_en = 1'b1;
    end
  end

  // Only a genuinely issued writer occupies entry 0; stalls/flushes insert an empty slot
  assign advance  = !bus.mem_busy;
  assign load_vld = !reset && (sel == ST_RUN) && bus.id_valid && writes_reg(op) && (ra != '0);

  hazard_scoreboard #(
    .REG_W (REG_W),
    .DEPTH (DEPTH)
  ) u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .advance   (advance),
    .load_vld  (load_vld),
    .load_dest (ra),
    .src_vld   (src_vld),
    .src_addr  (src_addr),
    .hazard    (hazard)
  );

  always_comb begin
    state_d = reset ? ST_RUN : sel;
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (!bus.pc_write_en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    count_q <= count_d;
  end

  assign bus.ctrl_state  = state_q;
  assign bus.stall_count = count_q;
endmodule
